// File: rtl/relu_argmax_stage.sv
// ----------------------------------------------------------------------------
// relu_argmax_stage
//
// Post-FC activation and classification stage, placed directly after fc_layer.
// On start it captures the packed neuron vector, then walks it one element
// per cycle: each element goes through the activation function, is written
// to its slot of out_data_flat, and is compared against the running maximum.
// When the walk is finished the winning index and value are published and
// done pulses for one cycle.
//
// Build option:
//   RELU_LEAKY_EN  defined   -> leaky ReLU, negatives become x >>> LEAK_SHIFT
//                  undefined -> plain ReLU, negatives become 0
//   Latency and all other behaviour are the same in both builds.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high
//   start          in   one-cycle request, captures in_data_flat when idle
//   in_data_flat   in   NUM_CLASSES signed elements, elem i at [i*DW +: DW]
//   busy           out  high while a run is scanning or finishing
//   done           out  one-cycle pulse, results valid from this cycle on
//   out_data_flat  out  activated elements, same packing as the input
//   class_idx      out  index of the largest activated element
//   max_value      out  activated value at class_idx
// ----------------------------------------------------------------------------
module relu_argmax_stage #(
    parameter int NUM_CLASSES = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int IDX_WIDTH   = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
    parameter int LEAK_SHIFT  = 3
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0]   in_data_flat,
    output logic                                busy,
    output logic                                done,
    output logic [NUM_CLASSES*DATA_WIDTH-1:0]   out_data_flat,
    output logic [IDX_WIDTH-1:0]                class_idx,
    output logic signed [DATA_WIDTH-1:0]        max_value
);

    // Reject configurations the datapath cannot represent. The leak shift is
    // checked in both builds so an override is caught before it matters.
    if (NUM_CLASSES < 1) begin : g_bad_num_classes
        $error("relu_argmax_stage: NUM_CLASSES must be at least 1");
    end
    if (LEAK_SHIFT < 0 || LEAK_SHIFT >= DATA_WIDTH) begin : g_bad_leak_shift
        $error("relu_argmax_stage: LEAK_SHIFT must lie in [0, DATA_WIDTH-1]");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    state_e                              state_q;
    logic [NUM_CLASSES*DATA_WIDTH-1:0]   data_q;
    logic [NUM_CLASSES*DATA_WIDTH-1:0]   out_q;
    logic [IDX_WIDTH-1:0]                ptr_q;
    logic [IDX_WIDTH-1:0]                best_idx_q;
    logic signed [DATA_WIDTH-1:0]        best_q;
    logic [IDX_WIDTH-1:0]                class_idx_q;
    logic signed [DATA_WIDTH-1:0]        max_q;
    logic                                busy_q;
    logic                                done_q;

    logic signed [DATA_WIDTH-1:0]        elem_d;
    logic signed [DATA_WIDTH-1:0]        act_d;
    logic                                take_d;
    logic                                last_d;

    // Activation of the element under the pointer and the arg-max decision.
    // The first element always seeds the running best; after that only a
    // strictly larger value replaces it, so ties keep the lowest index.
    always_comb begin
        elem_d = data_q[ptr_q*DATA_WIDTH +: DATA_WIDTH];
`ifdef RELU_LEAKY_EN
        act_d  = elem_d[DATA_WIDTH-1] ? (elem_d >>> LEAK_SHIFT) : elem_d;
`else
        act_d  = elem_d[DATA_WIDTH-1] ? '0 : elem_d;
`endif
        take_d = (ptr_q == '0) || (act_d > best_q);
        last_d = (ptr_q == LAST_IDX);
    end

    // Control FSM and datapath registers. DONE spans two cycles: the first
    // publishes the results and raises done, the second drops done and busy.
    // Keeping busy high through the done cycle means a start arriving with
    // done is ignored and only the following idle cycle can launch a run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            out_q       <= '0;
            ptr_q       <= '0;
            best_idx_q  <= '0;
            best_q      <= '0;
            class_idx_q <= '0;
            max_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        data_q  <= in_data_flat;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    out_q[ptr_q*DATA_WIDTH +: DATA_WIDTH] <= act_d;
                    if (take_d) begin
                        best_q     <= act_d;
                        best_idx_q <= ptr_q;
                    end
                    if (last_d) begin
                        state_q <= DONE;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                DONE: begin
                    if (!done_q) begin
                        done_q      <= 1'b1;
                        class_idx_q <= best_idx_q;
                        max_q       <= best_q;
                    end else begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        ptr_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign out_data_flat = out_q;
    assign class_idx     = class_idx_q;
    assign max_value     = max_q;

endmodule
